// File: rtl/regfile_write_sched.sv
// Round-robin write scheduler for the latch-based register file: two writers share
// one DIN bus, each write sequenced as SETUP / STROBE / HOLD so DIN is stable around W.
module regfile_write_sched #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int ADDRW = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0,
    input  logic [ADDRW-1:0] ADDR0,
    input  logic [WIDTH-1:0] DATA0,
    output logic             ACK0,
    input  logic             REQ1,
    input  logic [ADDRW-1:0] ADDR1,
    input  logic [WIDTH-1:0] DATA1,
    output logic             ACK1,
    output logic [WIDTH-1:0] REG_DIN,
    output logic [NREGS-1:0] REG_W,
    output logic             BUSY,
    output logic             ERR
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t           state;
    logic             last_gnt;
    logic             cur_port;
    logic [ADDRW-1:0] addr_p0;
    logic             elig0;
    logic             elig1;
    logic             pick;
    logic             grant;

    function automatic logic bad_addr(input logic [ADDRW-1:0] a);
        return int'(a) >= NREGS;
    endfunction

    function automatic logic [NREGS-1:0] decode(input logic [ADDRW-1:0] a);
        logic [NREGS-1:0] w;
        w = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (a == ADDRW'(i)) w[i] = 1'b1;
        end
        return w;
    endfunction

    // The port being ACKed in HOLD sits out the next grant.
    always_comb begin
        elig0 = REQ0 && !(state == HOLD && cur_port == 1'b0);
        elig1 = REQ1 && !(state == HOLD && cur_port == 1'b1);
        grant = (state == IDLE || state == HOLD) && (elig0 || elig1);
        pick  = (elig0 && elig1) ? ~last_gnt : elig1;
    end

    always_ff @(posedge CLK) begin
        if (grant) addr_p0 <= pick ? ADDR1 : ADDR0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            cur_port <= 1'b0;
            REG_DIN  <= '0;
            REG_W    <= '0;
            ACK0     <= 1'b0;
            ACK1     <= 1'b0;
            BUSY     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            ACK0  <= 1'b0;
            ACK1  <= 1'b0;
            ERR   <= 1'b0;
            REG_W <= '0;
            case (state)
                IDLE, HOLD: begin
                    if (grant) begin
                        state    <= SETUP;
                        cur_port <= pick;
                        last_gnt <= pick;
                        REG_DIN  <= pick ? DATA1 : DATA0;
                        BUSY     <= 1'b1;
                    end else begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                SETUP: begin
                    state <= STROBE;
                    if (!bad_addr(addr_p0)) REG_W <= decode(addr_p0);
                end
                STROBE: begin
                    state <= HOLD;
                    ACK0  <= ~cur_port;
                    ACK1  <= cur_port;
                    ERR   <= bad_addr(addr_p0);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed bench for regfile_write_sched with a behavioural model of the 8 Register latches.
module tb_regfile_write_sched;

    localparam int WIDTH = 16;
    localparam int NREGS = 8;
    localparam int ADDRW = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             REQ0 = 1'b0, REQ1 = 1'b0;
    logic [ADDRW-1:0] ADDR0 = '0, ADDR1 = '0;
    logic [WIDTH-1:0] DATA0 = '0, DATA1 = '0;
    logic             ACK0, ACK1, BUSY, ERR;
    logic [WIDTH-1:0] REG_DIN;
    logic [NREGS-1:0] REG_W;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [WIDTH-1:0] rf [NREGS];
    logic             mon_en = 1'b0;
    logic             twohot_seen = 1'b0;
    logic             din_chg_seen = 1'b0;
    logic [WIDTH-1:0] din_prev = '0;

    regfile_write_sched #(.WIDTH(WIDTH), .NREGS(NREGS), .ADDRW(ADDRW)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .ADDR0(ADDR0), .DATA0(DATA0), .ACK0(ACK0),
        .REQ1(REQ1), .ADDR1(ADDR1), .DATA1(DATA1), .ACK1(ACK1),
        .REG_DIN(REG_DIN), .REG_W(REG_W), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Register latch model: captures DIN on the rising edge of its W strobe.
    for (genvar g = 0; g < NREGS; g++) begin : g_rf
        always @(posedge REG_W[g]) rf[g] = REG_DIN;
    end

    always @(negedge CLK) begin
        if (mon_en) begin
            if ($countones(REG_W) > 1) twohot_seen = 1'b1;
            if ((|REG_W) && (REG_DIN != din_prev)) din_chg_seen = 1'b1;
        end
        din_prev = REG_DIN;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0;
        tick(); tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREGS; i++) rf[i] = '0;
        do_reset();
        total_cnt++; if (REG_W !== 8'h00) $display("FAIL reset_w got %h want 00", REG_W); else pass_cnt++;
        total_cnt++; if (REG_DIN !== 16'h0000) $display("FAIL reset_din got %h want 0000", REG_DIN); else pass_cnt++;
        total_cnt++; if ({ACK0, ACK1, BUSY, ERR} !== 4'b0000) $display("FAIL reset_ctrl got %b want 0000", {ACK0, ACK1, BUSY, ERR}); else pass_cnt++;
        mon_en = 1'b1;
    endtask

    task automatic test_single_write();
        REQ0 = 1'b1; ADDR0 = 4'd5; DATA0 = 16'hBEEF;
        tick();
        total_cnt++; if ({REG_DIN, REG_W, BUSY} !== {16'hBEEF, 8'h00, 1'b1}) $display("FAIL single_setup got din=%h w=%h busy=%b want BEEF 00 1", REG_DIN, REG_W, BUSY); else pass_cnt++;
        tick();
        total_cnt++; if ({REG_W, ACK0} !== {8'h20, 1'b0}) $display("FAIL single_strobe got w=%h ack0=%b want 20 0", REG_W, ACK0); else pass_cnt++;
        tick();
        total_cnt++; if ({REG_W, ACK0, ACK1, ERR} !== {8'h00, 3'b100}) $display("FAIL single_hold got w=%h ack=%b%b err=%b want 00 10 0", REG_W, ACK0, ACK1, ERR); else pass_cnt++;
        REQ0 = 1'b0;
        tick();
        total_cnt++; if ({ACK0, BUSY, REG_DIN} !== {2'b00, 16'hBEEF}) $display("FAIL single_idle got ack0=%b busy=%b din=%h want 0 0 BEEF", ACK0, BUSY, REG_DIN); else pass_cnt++;
        total_cnt++; if (rf[5] !== 16'hBEEF) $display("FAIL single_reg5 got %h want BEEF", rf[5]); else pass_cnt++;
    endtask

    task automatic test_contention();
        do_reset();
        REQ0 = 1'b1; ADDR0 = 4'd1; DATA0 = 16'h1234;
        REQ1 = 1'b1; ADDR1 = 4'd2; DATA1 = 16'h5678;
        tick(); tick(); tick();
        total_cnt++; if ({ACK0, ACK1} !== 2'b10) $display("FAIL cont_first_ack got %b%b want 10", ACK0, ACK1); else pass_cnt++;
        REQ0 = 1'b0;
        tick();
        total_cnt++; if ({BUSY, REG_DIN} !== {1'b1, 16'h5678}) $display("FAIL cont_no_gap got busy=%b din=%h want 1 5678", BUSY, REG_DIN); else pass_cnt++;
        tick();
        total_cnt++; if (REG_W !== 8'h04) $display("FAIL cont_strobe1 got %h want 04", REG_W); else pass_cnt++;
        tick();
        total_cnt++; if ({ACK0, ACK1} !== 2'b01) $display("FAIL cont_second_ack got %b%b want 01", ACK0, ACK1); else pass_cnt++;
        REQ1 = 1'b0;
        tick();
        total_cnt++; if (BUSY !== 1'b0) $display("FAIL cont_idle got busy=%b want 0", BUSY); else pass_cnt++;
        total_cnt++; if ({rf[1], rf[2]} !== {16'h1234, 16'h5678}) $display("FAIL cont_regs got %h %h want 1234 5678", rf[1], rf[2]); else pass_cnt++;
    endtask

    task automatic test_fairness();
        logic [NREGS-1:0] exp_w;
        logic [1:0]       exp_ack;
        do_reset();
        twohot_seen = 1'b0; din_chg_seen = 1'b0;
        REQ0 = 1'b1; ADDR0 = 4'd3; DATA0 = 16'hAAAA;
        REQ1 = 1'b1; ADDR1 = 4'd4; DATA1 = 16'h5555;
        tick();
        for (int n = 0; n < 4; n++) begin
            exp_w   = (n % 2 == 0) ? 8'h08 : 8'h10;
            exp_ack = (n % 2 == 0) ? 2'b10 : 2'b01;
            tick();
            total_cnt++; if (REG_W !== exp_w) $display("FAIL fair_strobe%0d got %h want %h", n, REG_W, exp_w); else pass_cnt++;
            tick();
            total_cnt++; if ({ACK0, ACK1} !== exp_ack) $display("FAIL fair_ack%0d got %b%b want %b", n, ACK0, ACK1, exp_ack); else pass_cnt++;
            if (n == 3) begin
                REQ0 = 1'b0; REQ1 = 1'b0;
            end
            tick();
        end
        total_cnt++; if (BUSY !== 1'b0) $display("FAIL fair_idle got busy=%b want 0", BUSY); else pass_cnt++;
        total_cnt++; if ({twohot_seen, din_chg_seen} !== 2'b00) $display("FAIL fair_monitor got twohot=%b dinchg=%b want 0 0", twohot_seen, din_chg_seen); else pass_cnt++;
        total_cnt++; if ({rf[3], rf[4]} !== {16'hAAAA, 16'h5555}) $display("FAIL fair_regs got %h %h want AAAA 5555", rf[3], rf[4]); else pass_cnt++;
    endtask

    task automatic test_bad_addr();
        logic [WIDTH-1:0] snap [NREGS];
        int               changed;
        for (int i = 0; i < NREGS; i++) snap[i] = rf[i];
        REQ1 = 1'b1; ADDR1 = 4'd8; DATA1 = 16'hDEAD;
        tick(); tick();
        total_cnt++; if (REG_W !== 8'h00) $display("FAIL bad_strobe got %h want 00", REG_W); else pass_cnt++;
        tick();
        total_cnt++; if ({ACK1, ERR, ACK0} !== 3'b110) $display("FAIL bad_ack_err got ack1=%b err=%b ack0=%b want 1 1 0", ACK1, ERR, ACK0); else pass_cnt++;
        REQ1 = 1'b0;
        tick();
        total_cnt++; if ({ERR, ACK1} !== 2'b00) $display("FAIL bad_err_pulse got err=%b ack1=%b want 0 0", ERR, ACK1); else pass_cnt++;
        changed = 0;
        for (int i = 0; i < NREGS; i++) if (rf[i] !== snap[i]) changed++;
        total_cnt++; if (changed != 0) $display("FAIL bad_regs got %0d changed want 0", changed); else pass_cnt++;
    endtask

    task automatic test_reset_in_strobe();
        REQ0 = 1'b1; ADDR0 = 4'd3; DATA0 = 16'h0F0F;
        tick(); tick();
        total_cnt++; if (REG_W !== 8'h08) $display("FAIL rst_pre_strobe got %h want 08", REG_W); else pass_cnt++;
        RST = 1'b1;
        tick();
        RST = 1'b0; REQ0 = 1'b0;
        total_cnt++; if ({REG_W, ACK0, BUSY} !== {8'h00, 2'b00}) $display("FAIL rst_abort got w=%h ack0=%b busy=%b want 00 0 0", REG_W, ACK0, BUSY); else pass_cnt++;
        tick();
        total_cnt++; if ({ACK0, ACK1, BUSY} !== 3'b000) $display("FAIL rst_no_ack got %b%b%b want 000", ACK0, ACK1, BUSY); else pass_cnt++;
        total_cnt++; if (rf[3] !== 16'h0F0F) $display("FAIL rst_reg3 got %h want 0F0F", rf[3]); else pass_cnt++;
        REQ0 = 1'b1; ADDR0 = 4'd6; DATA0 = 16'h1111;
        tick();
        total_cnt++; if ({BUSY, REG_DIN} !== {1'b1, 16'h1111}) $display("FAIL rst_fresh_setup got busy=%b din=%h want 1 1111", BUSY, REG_DIN); else pass_cnt++;
        tick();
        total_cnt++; if (REG_W !== 8'h40) $display("FAIL rst_fresh_strobe got %h want 40", REG_W); else pass_cnt++;
        tick();
        total_cnt++; if (ACK0 !== 1'b1) $display("FAIL rst_fresh_ack got %b want 1", ACK0); else pass_cnt++;
        REQ0 = 1'b0;
        tick();
        total_cnt++; if (rf[6] !== 16'h1111) $display("FAIL rst_fresh_reg6 got %h want 1111", rf[6]); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_fairness();
        test_bad_addr();
        test_reset_in_strobe();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
